ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Responder side of the byte-serial RAM interface driven by the memory controller (RWstate/RWaddr/WrtData out, ReadData in).
- Serves one byte per cycle from an on-chip byte RAM.
- Decodes an I/O window above the RAM:
  - an 8-deep transmit FIFO drained by a host/UART-style sink;
  - a one-byte receive holding register;
  - a status register.

Parameters:
ADDR_W, 17, width of RWaddr.
RAM_AW, 16, RAM depth is 2^RAM_AW bytes, occupying addresses [0, 2^RAM_AW).
IO_BASE, 17'h10000, base of I/O window; offsets 0 (TX/RX data), 1 (status); other offsets reserved.
FIFO_DEPTH, 8, TX FIFO entries (power of two).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-high.
RWstate  in  1  0 = read, 1 = write; sampled every cycle.
RWaddr  in  ADDR_W  byte address.
WrtData  in  8  write byte, valid when RWstate = 1.
ReadData  out  8  read byte; registered, valid the cycle after the address.
io_tx_valid  out  1  TX FIFO head valid.
io_tx_data  out  8  TX FIFO head byte.
io_tx_ready  in  1  sink accepts head when high with io_tx_valid.
io_rx_valid  in  1  incoming byte strobe.
io_rx_data  in  8  incoming byte.
io_overflow  out  1  sticky: TX write dropped while FIFO full.

Behaviour:
- Reset (async, immediate):
  - ReadData = 8'h00; io_tx_valid = 0; io_tx_data = 8'h00; io_overflow = 0.
  - TX FIFO empty (head = tail = count = 0); RX holding register empty, value 8'h00.
  - RAM contents not reset.
  - Reset mid-burst discards any in-flight read result.
- Every cycle is one transaction. There is no idle encoding: a read of address 0 is harmless.
- Read latency is exactly 1 cycle: address A presented in cycle N appears on ReadData during cycle N+1 and holds until the next edge.
- Back-to-back reads of A, A+1, A+2, A+3 return four consecutive bytes, one per cycle.
- RAM region write (addr < 2^RAM_AW):
  - byte stored at the rising edge; ReadData that cycle returns 8'h00;
  - a read of the same address in the next cycle returns the new byte (write-then-read coherent).
- RAM region read: ReadData <= mem[addr[RAM_AW-1:0]].
- Write IO_BASE+0:
  - if count < FIFO_DEPTH, push WrtData at the tail;
  - otherwise drop the byte and set io_overflow (sticky until rst).
- Read IO_BASE+0:
  - RX holding register full: return its byte and clear it;
  - empty: return 8'h00.
- Read IO_BASE+1 returns {5'b0, io_overflow, rx_full, tx_full}. Write is ignored.
- Reserved I/O offsets and addresses between 2^RAM_AW and IO_BASE: reads return 8'h00, writes are ignored.
- TX FIFO:
  - io_tx_valid = (count != 0); io_tx_data = entry at head (combinational from storage).
  - Pop on io_tx_valid & io_tx_ready.
  - Push and pop in the same cycle: count unchanged and both pointers advance. This is allowed even when full: the pop frees a slot, so the push is accepted and io_overflow is not set.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- RX holding register:
  - io_rx_valid loads io_rx_data and sets rx_full, overwriting any unread byte (no flag).
  - Same cycle as a CPU read of IO_BASE+0: the read returns the old byte, or 8'h00 if it was empty, and the register is left full with the new byte.
- ReadData is never combinational from RWaddr.

Test Plan:
- Reset, then read address 0 for 2 cycles -> ReadData = 00; io_tx_valid = 0; io_overflow = 0.
- Write AA, BB, CC, DD to 0x0100..0x0103 (one per cycle), then read 0x0100..0x0103 back-to-back -> ReadData = AA, BB, CC, DD in the 4 cycles after each address.
- Write 11 to 0x0200, then read 0x0200 in the next cycle -> 11 the following cycle.
- io_tx_ready = 0; write bytes 01..09 to IO_BASE -> status read = 8'h05 (overflow, tx_full); io_overflow = 1.
  - Then raise io_tx_ready -> 01..08 emerge in order, one per cycle; io_tx_valid drops after 08.
- FIFO full with io_tx_ready = 1; write 55 to IO_BASE in the same cycle -> byte accepted; io_overflow stays 0; 55 drains last.
- Pulse io_rx_valid with 5A; read IO_BASE -> 5A; read again -> 00.
  - Assert rst while a burst read is in progress -> ReadData = 00 immediately.

Source files
------------

// File: rtl/ram_responder.sv
// ram_responder: responder side of the byte-serial RAM interface.
// Every cycle carries one transaction (read or write). Addresses below
// 2^RAM_AW hit an on-chip byte RAM; an I/O window at IO_BASE exposes a
// transmit FIFO (offset 0, write), a receive holding register (offset 0,
// read) and a status byte (offset 1). ReadData is registered, so the byte
// for the address presented in cycle N is visible during cycle N+1.

module ram_responder #(
  parameter int                ADDR_W     = 17,
  parameter int                RAM_AW     = 16,
  parameter logic [ADDR_W-1:0] IO_BASE    = 17'h10000,
  parameter int                FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RWstate,
  input  logic [ADDR_W-1:0] RWaddr,
  input  logic [7:0]        WrtData,
  output logic [7:0]        ReadData,
  output logic              io_tx_valid,
  output logic [7:0]        io_tx_data,
  input  logic              io_tx_ready,
  input  logic              io_rx_valid,
  input  logic [7:0]        io_rx_data,
  output logic              io_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] IO_DATA  = IO_BASE;
  localparam logic [ADDR_W-1:0] IO_STAT  = IO_BASE + ADDR_W'(1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  // Byte RAM; contents deliberately survive reset.
  logic [7:0] mem [2**RAM_AW];

  // Transmit FIFO storage and bookkeeping.
  logic [7:0]       fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  // Receive holding register.
  logic             rx_full;
  logic [7:0]       rx_data;

  // Decode and handshake terms.
  logic             ram_hit;
  logic             io_data_hit;
  logic             io_stat_hit;
  logic             tx_nonempty;
  logic             tx_full;
  logic             tx_pop;
  logic             push_req;
  logic             tx_push;
  logic             tx_drop;
  logic             rx_take;
  logic [7:0]       rd_next;

  // Address decode plus FIFO push/pop/drop arbitration for this cycle.
  always_comb begin
    ram_hit     = (RWaddr[ADDR_W-1:RAM_AW] == '0);
    io_data_hit = (RWaddr == IO_DATA);
    io_stat_hit = (RWaddr == IO_STAT);
    tx_nonempty = (count != '0);
    tx_full     = (count == FULL_CNT);
    tx_pop      = tx_nonempty & io_tx_ready;
    push_req    = RWstate & io_data_hit;
    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // is still accepted and does not count as an overflow.
    tx_push     = push_req & (~tx_full | tx_pop);
    tx_drop     = push_req & tx_full & ~tx_pop;
    rx_take     = ~RWstate & io_data_hit;
  end

  // Select the byte to be registered onto ReadData at the next edge.
  always_comb begin
    rd_next = 8'h00;
    if (RWstate) begin
      rd_next = 8'h00;
    end else if (ram_hit) begin
      rd_next = mem[RWaddr[RAM_AW-1:0]];
    end else if (io_data_hit) begin
      rd_next = rx_full ? rx_data : 8'h00;
    end else if (io_stat_hit) begin
      rd_next = {5'b00000, io_overflow, rx_full, tx_full};
    end else begin
      rd_next = 8'h00;
    end
  end

  // RAM write port; no reset so the array maps onto plain memory.
  always_ff @(posedge clk) begin
    if (RWstate && ram_hit) begin
      mem[RWaddr[RAM_AW-1:0]] <= WrtData;
    end
  end

  // Registered read data; reset discards any in-flight read result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ReadData <= 8'h00;
    end else begin
      ReadData <= rd_next;
    end
  end

  // FIFO storage write at the tail; stale entries need no reset.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      fifo[tail] <= WrtData;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      io_overflow <= 1'b0;
    end else begin
      if (tx_push) begin
        tail <= tail + PTR_ONE;
      end
      if (tx_pop) begin
        head <= head + PTR_ONE;
      end
      case ({tx_push, tx_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (tx_drop) begin
        io_overflow <= 1'b1;
      end
    end
  end

  // Receive holding register: an incoming byte wins over a CPU read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_full <= 1'b0;
      rx_data <= 8'h00;
    end else if (io_rx_valid) begin
      rx_full <= 1'b1;
      rx_data <= io_rx_data;
    end else if (rx_take) begin
      rx_full <= 1'b0;
      rx_data <= 8'h00;
    end else begin
      rx_full <= rx_full;
      rx_data <= rx_data;
    end
  end

  // FIFO head presented to the sink; zero when nothing is queued.
  always_comb begin
    io_tx_valid = tx_nonempty;
    if (tx_nonempty) begin
      io_tx_data = fifo[head];
    end else begin
      io_tx_data = 8'h00;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: directed steps from the test plan followed by a
// randomized phase, all checked against a transaction-level model built from
// an associative byte array, a queue for the TX FIFO and two rx variables.

module tb_ram_responder;

  localparam int          ADDR_W  = 17;
  localparam logic [16:0] IO_BASE = 17'h10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        RWstate;
  logic [16:0] RWaddr;
  logic [7:0]  WrtData;
  logic [7:0]  ReadData;
  logic        io_tx_valid;
  logic [7:0]  io_tx_data;
  logic        io_tx_ready;
  logic        io_rx_valid;
  logic [7:0]  io_rx_data;
  logic        io_overflow;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] ram_m [int];
  logic [7:0] txq [$];
  logic       rx_full_m;
  logic [7:0] rx_m;
  logic       ovf_m;

  always #5 clk = ~clk;

  ram_responder #(
    .ADDR_W    (17),
    .RAM_AW    (16),
    .IO_BASE   (17'h10000),
    .FIFO_DEPTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RWstate    (RWstate),
    .RWaddr     (RWaddr),
    .WrtData    (WrtData),
    .ReadData   (ReadData),
    .io_tx_valid(io_tx_valid),
    .io_tx_data (io_tx_data),
    .io_tx_ready(io_tx_ready),
    .io_rx_valid(io_rx_valid),
    .io_rx_data (io_rx_data),
    .io_overflow(io_overflow)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rx_full_m = 1'b0;
    rx_m      = 8'h00;
    ovf_m     = 1'b0;
  endtask

  // One bus cycle: drive inputs, advance the model, check after the edge.
  task automatic step(input logic rw, input logic [16:0] addr, input logic [7:0] wd,
                      input logic txr, input logic rxv, input logic [7:0] rxd);
    logic [7:0] exp;
    bit known;
    bit pop;
    bit push;
    int sz;
    RWstate     = rw;
    RWaddr      = addr;
    WrtData     = wd;
    io_tx_ready = txr;
    io_rx_valid = rxv;
    io_rx_data  = rxd;
    sz    = txq.size();
    pop   = (sz != 0) && txr;
    push  = 1'b0;
    exp   = 8'h00;
    known = 1'b1;
    if (!rw) begin
      if (addr < 17'h10000) begin
        if (ram_m.exists(int'(addr))) exp = ram_m[int'(addr)];
        else known = 1'b0;
      end else if (addr == IO_BASE) begin
        exp       = rx_full_m ? rx_m : 8'h00;
        rx_full_m = 1'b0;
        rx_m      = 8'h00;
      end else if (addr == IO_BASE + 17'd1) begin
        exp = {5'b00000, ovf_m, rx_full_m, (sz == 8)};
      end
    end else begin
      if (addr < 17'h10000) ram_m[int'(addr)] = wd;
      else if (addr == IO_BASE) begin
        if (sz < 8 || pop) push = 1'b1;
        else ovf_m = 1'b1;
      end
    end
    if (pop) void'(txq.pop_front());
    if (push) txq.push_back(wd);
    if (rxv) begin
      rx_full_m = 1'b1;
      rx_m      = rxd;
    end
    @(posedge clk);
    #1;
    if (known) chk("read_data", ReadData, exp);
    chk("tx_valid", {7'b0, io_tx_valid}, {7'b0, (txq.size() != 0)});
    if (txq.size() != 0) chk("tx_data", io_tx_data, txq[0]);
    chk("overflow", {7'b0, io_overflow}, {7'b0, ovf_m});
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_read_data", ReadData, 8'h00);
    chk("rst_tx_valid", {7'b0, io_tx_valid}, 8'h00);
    chk("rst_overflow", {7'b0, io_overflow}, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0]  d;
    logic [16:0] a;
    int          kind;
    rst         = 1'b1;
    RWstate     = 1'b0;
    RWaddr      = 17'h00000;
    WrtData     = 8'h00;
    io_tx_ready = 1'b0;
    io_rx_valid = 1'b0;
    io_rx_data  = 8'h00;
    model_reset();
    #12;
    chk("reset_read_data", ReadData, 8'h00);
    chk("reset_tx_valid", {7'b0, io_tx_valid}, 8'h00);
    chk("reset_tx_data", io_tx_data, 8'h00);
    chk("reset_overflow", {7'b0, io_overflow}, 8'h00);
    rst = 1'b0;

    // Address 0 is given a known value, then read twice
    step(1'b1, 17'h00000, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 17'h00000, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 17'h00000, 8'h00, 1'b0, 1'b0, 8'h00);

    // Burst write then back-to-back burst read
    step(1'b1, 17'h00100, 8'hAA, 1'b0, 1'b0, 8'h00);
    step(1'b1, 17'h00101, 8'hBB, 1'b0, 1'b0, 8'h00);
    step(1'b1, 17'h00102, 8'hCC, 1'b0, 1'b0, 8'h00);
    step(1'b1, 17'h00103, 8'hDD, 1'b0, 1'b0, 8'h00);
    step(1'b0, 17'h00100, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("burst_0", ReadData, 8'hAA);
    step(1'b0, 17'h00101, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("burst_1", ReadData, 8'hBB);
    step(1'b0, 17'h00102, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("burst_2", ReadData, 8'hCC);
    step(1'b0, 17'h00103, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("burst_3", ReadData, 8'hDD);

    // Write-then-read coherence
    step(1'b1, 17'h00200, 8'h11, 1'b0, 1'b0, 8'h00);
    step(1'b0, 17'h00200, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("wr_then_rd", ReadData, 8'h11);

    // Reset asserted in the middle of a burst read
    step(1'b0, 17'h00100, 8'h00, 1'b0, 1'b0, 8'h00);
    RWaddr = 17'h00101;
    #2;
    pulse_reset();

    // Overflow: nine writes with the sink stalled
    for (int i = 1; i <= 9; i++) begin
      d = 8'(i);
      step(1'b1, IO_BASE, d, 1'b0, 1'b0, 8'h00);
    end
    step(1'b0, IO_BASE + 17'd1, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("status_ovf_full", ReadData, 8'h05);
    chk("overflow_set", {7'b0, io_overflow}, 8'h01);
    for (int i = 0; i < 9; i++) step(1'b0, 17'h00000, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("drained", {7'b0, io_tx_valid}, 8'h00);

    // Push while full with a simultaneous pop
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      d = 8'h20 + 8'(i);
      step(1'b1, IO_BASE, d, 1'b0, 1'b0, 8'h00);
    end
    step(1'b1, IO_BASE, 8'h55, 1'b1, 1'b0, 8'h00);
    chk("full_push_no_ovf", {7'b0, io_overflow}, 8'h00);
    for (int i = 0; i < 9; i++) step(1'b0, 17'h00000, 8'h00, 1'b1, 1'b0, 8'h00);

    // Receive holding register
    step(1'b0, 17'h00000, 8'h00, 1'b0, 1'b1, 8'h5A);
    step(1'b0, IO_BASE, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("rx_read", ReadData, 8'h5A);
    step(1'b0, IO_BASE, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("rx_empty", ReadData, 8'h00);
    step(1'b0, IO_BASE, 8'h00, 1'b0, 1'b1, 8'h77);
    step(1'b0, IO_BASE + 17'd1, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, IO_BASE, 8'h00, 1'b0, 1'b0, 8'h00);

    // Randomized phase over RAM, I/O and reserved addresses
    for (int i = 0; i < 16; i++) step(1'b1, 17'h00300 + 17'(i), 8'($urandom), 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0, 1:    a = 17'h00300 + 17'($urandom_range(0, 15));
        2, 3:    a = IO_BASE;
        4:       a = IO_BASE + 17'd1;
        5:       a = IO_BASE + 17'($urandom_range(2, 7));
        default: a = 17'h1FFFF;
      endcase
      step(1'($urandom_range(0, 1)), a, 8'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
